// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the data-processor memory arbitration logic.
// Provides: arb_state_t (arbiter FSM states), ARB_NUM_MASTERS (master port count).
// No logic; imported by wb_mem_arbiter.
package ecap5_dproc_pkg;

  localparam int ARB_NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_outstanding_counter.sv
// Counts accepted-but-unacknowledged Wishbone requests for the current grant.
// Latency: count updates on the edge after inc/dec; full/empty are combinational from count.
// Backpressure: none itself; owner must gate inc with full. dec at zero is ignored.
// Ports: clk, rst (sync, active high), inc, dec, clear -> count, full, empty.
module wb_outstanding_counter #(
  parameter int MAX = 4,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  assign full  = (count == CW'(MAX));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !empty) begin
      // A stray ack with nothing outstanding must not wrap the count.
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares one pipelined Wishbone B4 slave between instruction fetch (0) and load/store (1).
// Latency: grant one cycle after cyc rises; request/response paths are combinational while granted.
// Backpressure: master stalled by slave stall or when MAX_OUTSTANDING requests are in flight.
// Ports: clk_i, rst_i (sync, active high); m_wb_* master-side bundle (2 lanes);
//        s_wb_* slave-side bundle; timeout_o watchdog pulse.
// Optional: define WB_MEM_ARBITER_TIMEOUT_EN to enable the ack watchdog (TIMEOUT_CYCLES).
module wb_mem_arbiter
  import ecap5_dproc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ARB_NUM_MASTERS-1:0][31:0] m_wb_adr_i,
  input  logic [ARB_NUM_MASTERS-1:0][31:0] m_wb_dat_i,
  output logic [ARB_NUM_MASTERS-1:0][31:0] m_wb_dat_o,
  input  logic [ARB_NUM_MASTERS-1:0]       m_wb_we_i,
  input  logic [ARB_NUM_MASTERS-1:0][3:0]  m_wb_sel_i,
  input  logic [ARB_NUM_MASTERS-1:0]       m_wb_stb_i,
  input  logic [ARB_NUM_MASTERS-1:0]       m_wb_cyc_i,
  output logic [ARB_NUM_MASTERS-1:0]       m_wb_ack_o,
  output logic [ARB_NUM_MASTERS-1:0]       m_wb_stall_o,
  output logic [31:0]                      s_wb_adr_o,
  output logic [31:0]                      s_wb_dat_o,
  input  logic [31:0]                      s_wb_dat_i,
  output logic                             s_wb_we_o,
  output logic [3:0]                       s_wb_sel_o,
  output logic                             s_wb_stb_o,
  output logic                             s_wb_cyc_o,
  input  logic                             s_wb_ack_i,
  input  logic                             s_wb_stall_i,
  output logic                             timeout_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t       state;
  arb_state_t       next_state;
  logic             last_grant;
  logic             next_last;
  logic             granted;
  logic             gnt_idx;
  logic             release_cyc;
  logic [CNT_W-1:0] cnt;
  logic             cnt_full;
  logic             cnt_empty;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             cnt_clear;

  assign granted     = (state == ARB_GRANT0) || (state == ARB_GRANT1);
  assign gnt_idx     = (state == ARB_GRANT1);
  assign release_cyc = granted && !m_wb_cyc_i[gnt_idx];

  // Read data fans out to both lanes; only the granted master sees an ack.
  assign m_wb_dat_o = {ARB_NUM_MASTERS{s_wb_dat_i}};

  assign cnt_inc   = s_wb_stb_o && !s_wb_stall_i;
  assign cnt_dec   = granted && s_wb_ack_i;
  // Aborting the cycle drops all in-flight requests, so late acks land on an empty count.
  assign cnt_clear = !granted || release_cyc || timeout_o;

  wb_outstanding_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (cnt_inc),
    .dec   (cnt_dec),
    .clear (cnt_clear),
    .count (cnt),
    .full  (cnt_full),
    .empty (cnt_empty)
  );

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // wd_cnt holds the number of completed ack-less busy cycles, so the pulse
  // lands in the TIMEOUT_CYCLES-th such cycle.
  assign timeout_o = granted && !cnt_empty && !s_wb_ack_i &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_empty || s_wb_ack_i || timeout_o) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (|TIMEOUT_CYCLES) ^ cnt_empty;
  assign timeout_o          = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= next_state;
      last_grant <= next_last;
    end
  end

  always_comb begin
    next_state   = state;
    next_last    = last_grant;
    s_wb_adr_o   = '0;
    s_wb_dat_o   = '0;
    s_wb_we_o    = 1'b0;
    s_wb_sel_o   = '0;
    s_wb_stb_o   = 1'b0;
    s_wb_cyc_o   = 1'b0;
    m_wb_ack_o   = '0;
    m_wb_stall_o = '1;

    if (granted) begin
      s_wb_adr_o = m_wb_adr_i[gnt_idx];
      s_wb_dat_o = m_wb_dat_i[gnt_idx];
      s_wb_we_o  = m_wb_we_i[gnt_idx];
      s_wb_sel_o = m_wb_sel_i[gnt_idx];
      s_wb_cyc_o = m_wb_cyc_i[gnt_idx];
      s_wb_stb_o = m_wb_stb_i[gnt_idx] && m_wb_cyc_i[gnt_idx] && !cnt_full;
      m_wb_stall_o[gnt_idx] = s_wb_stall_i || cnt_full;
      m_wb_ack_o[gnt_idx]   = s_wb_ack_i && m_wb_cyc_i[gnt_idx];

      // Handover goes straight to the other master when it is waiting.
      if (release_cyc) begin
        if (m_wb_cyc_i[!gnt_idx]) begin
          next_state = gnt_idx ? ARB_GRANT0 : ARB_GRANT1;
          next_last  = !gnt_idx;
        end else begin
          next_state = ARB_IDLE;
        end
      end

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
      if (timeout_o) begin
        next_state = ARB_IDLE;
        next_last  = gnt_idx;
      end
`endif
    end else begin
      if (m_wb_cyc_i[0] && m_wb_cyc_i[1]) begin
        next_state = last_grant ? ARB_GRANT0 : ARB_GRANT1;
        next_last  = !last_grant;
      end else if (m_wb_cyc_i[0]) begin
        next_state = ARB_GRANT0;
        next_last  = 1'b0;
      end else if (m_wb_cyc_i[1]) begin
        next_state = ARB_GRANT1;
        next_last  = 1'b1;
      end else begin
        next_state = ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=8).
// Inputs change #1 after the rising edge; outputs are checked one further #1 later.
module tb_wb_mem_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0][31:0]  m_wb_adr_i;
  logic [1:0][31:0]  m_wb_dat_i;
  logic [1:0][31:0]  m_wb_dat_o;
  logic [1:0]        m_wb_we_i;
  logic [1:0][3:0]   m_wb_sel_i;
  logic [1:0]        m_wb_stb_i;
  logic [1:0]        m_wb_cyc_i;
  logic [1:0]        m_wb_ack_o;
  logic [1:0]        m_wb_stall_o;
  logic [31:0]       s_wb_adr_o;
  logic [31:0]       s_wb_dat_o;
  logic [31:0]       s_wb_dat_i;
  logic              s_wb_we_o;
  logic [3:0]        s_wb_sel_o;
  logic              s_wb_stb_o;
  logic              s_wb_cyc_o;
  logic              s_wb_ack_i;
  logic              s_wb_stall_i;
  logic              timeout_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  wb_mem_arbiter #(
    .MAX_OUTSTANDING (4),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m_wb_adr_i   (m_wb_adr_i),
    .m_wb_dat_i   (m_wb_dat_i),
    .m_wb_dat_o   (m_wb_dat_o),
    .m_wb_we_i    (m_wb_we_i),
    .m_wb_sel_i   (m_wb_sel_i),
    .m_wb_stb_i   (m_wb_stb_i),
    .m_wb_cyc_i   (m_wb_cyc_i),
    .m_wb_ack_o   (m_wb_ack_o),
    .m_wb_stall_o (m_wb_stall_o),
    .s_wb_adr_o   (s_wb_adr_o),
    .s_wb_dat_o   (s_wb_dat_o),
    .s_wb_dat_i   (s_wb_dat_i),
    .s_wb_we_o    (s_wb_we_o),
    .s_wb_sel_o   (s_wb_sel_o),
    .s_wb_stb_o   (s_wb_stb_o),
    .s_wb_cyc_o   (s_wb_cyc_o),
    .s_wb_ack_i   (s_wb_ack_i),
    .s_wb_stall_i (s_wb_stall_i),
    .timeout_o    (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got=running want=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i        = 1'b1;
    m_wb_adr_i   = '0;
    m_wb_dat_i   = '0;
    m_wb_we_i    = '0;
    m_wb_sel_i   = '0;
    m_wb_stb_i   = '0;
    m_wb_cyc_i   = '0;
    s_wb_dat_i   = '0;
    s_wb_ack_i   = 1'b0;
    s_wb_stall_i = 1'b0;
    step();
    step();
    settle();
    // ---- reset state
    chk("rst_stall",   32'(m_wb_stall_o), 32'h3);
    chk("rst_ack",     32'(m_wb_ack_o),   32'h0);
    chk("rst_scyc",    32'(s_wb_cyc_o),   32'h0);
    chk("rst_sstb",    32'(s_wb_stb_o),   32'h0);
    chk("rst_sadr",    s_wb_adr_o,        32'h0);
    chk("rst_timeout", 32'(timeout_o),    32'h0);
    rst_i = 1'b0;

    // ---- single master 0 read
    m_wb_cyc_i[0] = 1'b1; m_wb_stb_i[0] = 1'b1; m_wb_adr_i[0] = 32'h100; m_wb_sel_i[0] = 4'hF;
    settle();
    chk("t1_idle_sstb", 32'(s_wb_stb_o), 32'h0);
    step();
    settle();
    chk("t1_sadr",  s_wb_adr_o,          32'h100);
    chk("t1_sstb",  32'(s_wb_stb_o),     32'h1);
    chk("t1_stall", 32'(m_wb_stall_o),   32'h2);
    step();
    m_wb_stb_i[0] = 1'b0; s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hCAFE_0001;
    settle();
    chk("t1_ack",   32'(m_wb_ack_o),     32'h1);
    chk("t1_rdat",  m_wb_dat_o[0],       32'hCAFE_0001);
    chk("t1_stall1",32'(m_wb_stall_o[1]),32'h1);
    step();
    s_wb_ack_i = 1'b0; m_wb_cyc_i[0] = 1'b0;
    settle();
    chk("t1_rel_scyc", 32'(s_wb_cyc_o), 32'h0);
    step();
    settle();
    chk("t1_idle_stall", 32'(m_wb_stall_o), 32'h3);

    // ---- tie after reset, handover, rotation
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    m_wb_adr_i[0] = 32'h200; m_wb_adr_i[1] = 32'h300; m_wb_cyc_i = 2'b11;
    step();
    settle();
    chk("t2_tie_adr",   s_wb_adr_o,        32'h200);
    chk("t2_tie_stall", 32'(m_wb_stall_o), 32'h2);
    step();
    m_wb_cyc_i = 2'b10;
    settle();
    chk("t2_rel_scyc", 32'(s_wb_cyc_o), 32'h0);
    step();
    settle();
    chk("t2_hand_adr",   s_wb_adr_o,        32'h300);
    chk("t2_hand_scyc",  32'(s_wb_cyc_o),   32'h1);
    chk("t2_hand_stall", 32'(m_wb_stall_o), 32'h1);
    m_wb_cyc_i = 2'b00;
    step();
    m_wb_cyc_i = 2'b11;
    settle();
    chk("t2_idle_stall", 32'(m_wb_stall_o), 32'h3);
    step();
    settle();
    chk("t2_tie2_adr", s_wb_adr_o, 32'h200);
    m_wb_cyc_i = 2'b10;
    step();
    settle();
    chk("t2_hand2_adr", s_wb_adr_o, 32'h300);
    m_wb_cyc_i = 2'b00;
    step();
    m_wb_cyc_i = 2'b01;
    step();
    settle();
    chk("t2_solo0_adr", s_wb_adr_o, 32'h200);
    m_wb_cyc_i = 2'b00;
    step();
    m_wb_cyc_i = 2'b11;
    step();
    settle();
    chk("t2_tie3_adr", s_wb_adr_o, 32'h300);
    m_wb_cyc_i = 2'b00;
    step();

    // ---- pipelined burst from master 1, acks held
    m_wb_cyc_i[1] = 1'b1; m_wb_stb_i[1] = 1'b1; m_wb_adr_i[1] = 32'h1000;
    step();
    for (int i = 0; i < 4; i++) begin
      m_wb_adr_i[1] = 32'h1000 + 32'(4 * i);
      settle();
      chk($sformatf("t3_acc%0d_stb", i),   32'(s_wb_stb_o),   32'h1);
      chk($sformatf("t3_acc%0d_stall", i), 32'(m_wb_stall_o), 32'h1);
      chk($sformatf("t3_acc%0d_adr", i),   s_wb_adr_o,        32'h1000 + 32'(4 * i));
      step();
    end
    m_wb_adr_i[1] = 32'h1010;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("t3_full%0d_stall", i), 32'(m_wb_stall_o), 32'h3);
      chk($sformatf("t3_full%0d_stb", i),   32'(s_wb_stb_o),   32'h0);
      step();
    end
    s_wb_ack_i = 1'b1;
    settle();
    chk("t3_ack_route", 32'(m_wb_ack_o), 32'h2);
    chk("t3_ack_stall", 32'(m_wb_stall_o), 32'h3);
    step();
    s_wb_ack_i = 1'b0;
    settle();
    chk("t3_reopen_stall", 32'(m_wb_stall_o), 32'h1);
    chk("t3_reopen_adr",   s_wb_adr_o,        32'h1010);
    step();
    settle();
    chk("t3_refull_stall", 32'(m_wb_stall_o), 32'h3);
    chk("t3_refull_cnt",   32'(dut.cnt),      32'h4);
    m_wb_cyc_i[1] = 1'b0; m_wb_stb_i[1] = 1'b0;
    step();

    // ---- slave stall held for three cycles
    m_wb_cyc_i[0] = 1'b1; m_wb_stb_i[0] = 1'b1; m_wb_we_i[0] = 1'b1;
    m_wb_adr_i[0] = 32'h400; m_wb_dat_i[0] = 32'h55AA_1234; m_wb_sel_i[0] = 4'hC;
    s_wb_stall_i = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t4_s%0d_mstall", i), 32'(m_wb_stall_o), 32'h3);
      chk($sformatf("t4_s%0d_sstb", i),   32'(s_wb_stb_o),   32'h1);
      chk($sformatf("t4_s%0d_adr", i),    s_wb_adr_o,        32'h400);
      chk($sformatf("t4_s%0d_dat", i),    s_wb_dat_o,        32'h55AA_1234);
      chk($sformatf("t4_s%0d_sel", i),    32'(s_wb_sel_o),   32'hC);
      chk($sformatf("t4_s%0d_cnt", i),    32'(dut.cnt),      32'h0);
      step();
    end
    s_wb_stall_i = 1'b0;
    settle();
    chk("t4_go_mstall", 32'(m_wb_stall_o), 32'h2);
    chk("t4_go_we",     32'(s_wb_we_o),    32'h1);
    step();
    m_wb_stb_i[0] = 1'b0;
    settle();
    chk("t4_cnt1", 32'(dut.cnt), 32'h1);
    s_wb_ack_i = 1'b1;
    step();
    s_wb_ack_i = 1'b0;
    settle();
    chk("t4_cnt0", 32'(dut.cnt), 32'h0);
    m_wb_cyc_i[0] = 1'b0; m_wb_we_i[0] = 1'b0;
    step();

    // ---- abort with two outstanding, then late acks
    m_wb_cyc_i[0] = 1'b1; m_wb_stb_i[0] = 1'b1;
    step();
    step();
    step();
    m_wb_stb_i[0] = 1'b0;
    settle();
    chk("t5_cnt2", 32'(dut.cnt), 32'h2);
    m_wb_cyc_i[0] = 1'b0; s_wb_ack_i = 1'b1;
    settle();
    chk("t5_rel_ack",  32'(m_wb_ack_o), 32'h0);
    chk("t5_rel_scyc", 32'(s_wb_cyc_o), 32'h0);
    step();
    settle();
    chk("t5_late_ack",   32'(m_wb_ack_o),   32'h0);
    chk("t5_idle_stall", 32'(m_wb_stall_o), 32'h3);
    chk("t5_idle_cnt",   32'(dut.cnt),      32'h0);
    step();
    s_wb_ack_i = 1'b0;
    settle();
    chk("t5_cnt_stays0", 32'(dut.cnt), 32'h0);

    // ---- one request, never acked: watchdog behaviour
    m_wb_cyc_i[1] = 1'b1; m_wb_stb_i[1] = 1'b1;
    step();
    settle();
    chk("t6_sstb", 32'(s_wb_stb_o), 32'h1);
    step();
    m_wb_stb_i[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle();
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
      chk($sformatf("t6_to_k%0d", k), 32'(timeout_o), (k == 8) ? 32'h1 : 32'h0);
`else
      chk($sformatf("t6_to_k%0d", k), 32'(timeout_o), 32'h0);
`endif
      step();
    end
`ifndef WB_MEM_ARBITER_TIMEOUT_EN
    repeat (4) step();
    settle();
    chk("t6_held_scyc",  32'(s_wb_cyc_o),   32'h1);
    chk("t6_held_stall", 32'(m_wb_stall_o), 32'h1);
`endif

    // ---- reset mid-transaction, then a late ack
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; m_wb_cyc_i = 2'b00; s_wb_ack_i = 1'b1;
    settle();
    chk("t7_stall",    32'(m_wb_stall_o), 32'h3);
    chk("t7_scyc",     32'(s_wb_cyc_o),   32'h0);
    chk("t7_late_ack", 32'(m_wb_ack_o),   32'h0);
    step();
    s_wb_ack_i = 1'b0;
    settle();
    chk("t7_cnt", 32'(dut.cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Shares one pipelined Wishbone B4 slave port between two Wishbone masters: index 0 is instruction fetch (ifm) and index 1 is load/store (lsm).
- Sits between the core masters and the memory/bus slave.
- Holds the grant for a whole bus cycle (cyc high), tracks outstanding requests, and rotates priority round-robin.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests per grant (≥1).
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_wb_adr_i  in  [1:0][31:0]  master addresses
- m_wb_dat_i  in  [1:0][31:0]  master write data
- m_wb_dat_o  out  [1:0][31:0]  read data to masters
- m_wb_we_i  in  [1:0]  master write enables
- m_wb_sel_i  in  [1:0][3:0]  master byte selects
- m_wb_stb_i  in  [1:0]  master strobes
- m_wb_cyc_i  in  [1:0]  master cycle requests
- m_wb_ack_o  out  [1:0]  acks to masters
- m_wb_stall_o  out  [1:0]  stalls to masters
- s_wb_adr_o  out  32  slave address
- s_wb_dat_o  out  32  slave write data
- s_wb_dat_i  in  32  slave read data
- s_wb_we_o  out  1  slave write enable
- s_wb_sel_o  out  4  slave byte select
- s_wb_stb_o  out  1  slave strobe
- s_wb_cyc_o  out  1  slave cycle
- s_wb_ack_i  in  1  slave ack
- s_wb_stall_i  in  1  slave stall
- timeout_o  out  1  one-cycle watchdog pulse; tied 0 without the optional feature

Behaviour:
- Reset values:
  - state IDLE, outstanding count 0, last_grant 1 (so master 0 wins the first tie).
  - All s_wb_* outputs 0, m_wb_ack_o 0, m_wb_stall_o 2'b11, timeout_o 0.
- States are IDLE, GRANT0 and GRANT1; state is registered, all muxing is combinational from state.
- IDLE:
  - Both stalls 1, s_cyc/s_stb 0, slave address/data/sel/we driven 0.
  - If exactly one cyc_i is high, grant it next cycle.
  - If both are high, grant !last_grant and set last_grant to the winner.
  - Grant latency: cyc_i rises in cycle N, GRANTx in N+1, earliest slave stb in N+1.
- GRANTx:
  - s_wb_* outputs = master x signals.
  - s_stb_o = stb_i[x] & ~cnt_full.
  - m_stall_o[x] = s_stall_i | cnt_full; m_stall_o[!x] = 1.
  - m_ack_o[x] = s_ack_i; m_ack_o[!x] = 0.
  - m_dat_o both lanes = s_dat_i; non-granted masters ignore it because ack is 0.
- Outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on s_stb_o & ~s_stall_i; −1 on s_ack_i; unchanged when both occur in the same cycle.
  - cnt_full = (cnt == MAX_OUTSTANDING).
  - An ack arriving with cnt 0 is ignored; the count never underflows.
- Release:
  - When cyc_i[x] drops, the cycle is aborted (Wishbone semantics): s_cyc falls in the same cycle and the counter clears to 0.
  - Next state is GRANT(!x) if cyc_i[!x] is high, otherwise IDLE. A back-to-back handover costs 0 idle cycles; last_grant is updated.
- Grant is never revoked while cyc_i[x] is held, except by the watchdog; starvation is bounded by the master releasing cyc.
- Reset mid-transaction: on the next edge, return to reset values; a late slave ack is ignored (cnt 0).

Optional Feature:
- Macro: WB_MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs while cnt > 0 and resets on every s_ack_i.
  - On reaching TIMEOUT_CYCLES it pulses timeout_o for 1 cycle, forces the state to IDLE, clears cnt, and sets last_grant to the timed-out master.
- Undefined: no watchdog logic; timeout_o is tied 0.

Decomposition:
- ecap5_dproc_pkg gets:
  - typedef enum logic[1:0] arb_state_t {ARB_IDLE, ARB_GRANT0, ARB_GRANT1};
  - localparam ARB_NUM_MASTERS = 2.
- One sub-module, wb_outstanding_counter:
  - inputs: inc, dec, clear, sync reset.
  - outputs: count, full, empty.
  - parameter MAX.

Test Plan:
- Single master 0: cyc/stb with adr 0x100, slave no stall, ack 1 cycle later → s_adr_o 0x100 in cycle N+1; m_ack_o[0] 1 in N+2; m_stall_o[1] 1 throughout.
- Simultaneous cyc from both after reset → GRANT0 first. Master 0 drops cyc → GRANT1 on the next cycle with no IDLE cycle. Repeat tie from IDLE → master 0 granted again only if master 1 won last.
- Pipelined burst of 6 stb from master 1, slave holds acks, MAX_OUTSTANDING=4 → exactly 4 accepted; m_stall_o[1] 1 from the 5th; the first ack re-enables acceptance; no ack reaches master 0.
- Slave stall_i 1 for 3 cycles → master sees stall, cnt stays 0, s_stb_o remains asserted with stable adr/dat/sel.
- Master 0 drops cyc with cnt=2, then the slave acks → acks not forwarded; state IDLE; cnt 0.
- With WB_MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8: one request, no ack → timeout_o pulses on the 8th cycle and state goes to IDLE. Without the macro: timeout_o stays 0 and the grant is held.
